// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, column drive table and key map for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    PRESS_DB = 2'd1,
    REL_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic [3:0] keycode(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-index active-low row wins when several rows are pulled low together.
  function automatic logic [1:0] first_low(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - 4-bit two-flop synchroniser, resets to idle (all rows high)
module keypad_sync (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [3:0] rows_i,
  output logic [3:0] rows_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= rows_i;
      sync_q <= meta_q;
    end
  end

  assign rows_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad scan/debounce front end; KEYPAD_DECIMAL_FILTER_EN suppresses A-F strobes
module keypad_scanner #(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] user_digit,
  output logic       user_latch,
  output logic       key_held
);

  import keypad_pkg::*;

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [3:0]       digit_q, digit_d;
  logic             latch_q, latch_d;
  logic             held_q, held_d;

  logic [3:0] rs;
  logic       row_bit;
  logic [3:0] key_code;

  keypad_sync u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .rows_i  (row_in),
    .rows_o  (rs)
  );

  assign row_bit  = rs[row_q];
  assign key_code = keycode(row_q, col_q);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    div_d   = div_q;
    db_d    = db_q;
    digit_d = digit_q;
    latch_d = 1'b0;
    held_d  = held_q;

    case (state_q)
      SCAN: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (&rs) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = first_low(rs);
            db_d    = '0;
            state_d = PRESS_DB;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      PRESS_DB: begin
        if (row_bit) begin
          col_d   = col_q + 2'd1;
          div_d   = '0;
          state_d = SCAN;
        end else if (db_q == DB_LAST) begin
          db_d    = '0;
          held_d  = 1'b1;
          state_d = REL_WAIT;
`ifdef KEYPAD_DECIMAL_FILTER_EN
          if (key_code <= 4'd9) begin
            digit_d = key_code;
            latch_d = 1'b1;
          end
`else
          digit_d = key_code;
          latch_d = 1'b1;
`endif
        end else begin
          db_d = db_q + 1'b1;
        end
      end

      REL_WAIT: begin
        // Any low sample restarts the release count; only a clean high run counts.
        if (!row_bit) begin
          db_d = '0;
        end else if (db_q == DB_LAST) begin
          db_d    = '0;
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
          div_d   = '0;
          state_d = SCAN;
        end else begin
          db_d = db_q + 1'b1;
        end
      end

      default: begin
        state_d = SCAN;
        div_d   = '0;
        db_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      div_q   <= '0;
      db_q    <= '0;
      digit_q <= 4'd0;
      latch_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      div_q   <= div_d;
      db_q    <= db_d;
      digit_q <= digit_d;
      latch_q <= latch_d;
      held_q  <= held_d;
    end
  end

  assign col_out    = COL_DRIVE[col_q];
  assign user_digit = digit_q;
  assign user_latch = latch_q;
  assign key_held   = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner with a matrix keypad model
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] user_digit;
  logic       user_latch;
  logic       key_held;

  logic [3:0] pressed [4];
  int         checks;
  int         failures;
  int         latch_cnt;
  int         double_latch;
  logic       latch_prev;

  keypad_scanner #(
    .SCAN_DIV        (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .user_digit (user_digit),
    .user_latch (user_latch),
    .key_held   (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r is pulled low when a pressed key in row r sits on the driven (low) column.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      row_in[r] = ~(|(pressed[r] & ~col_out));
    end
  end

  always @(negedge clk) begin
    if (user_latch) latch_cnt++;
    if (user_latch && latch_prev) double_latch++;
    latch_prev = user_latch;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++) pressed[r] = 4'b0000;
  endtask

  // Leaves the bench at a negedge with reset just released and no posedge seen since.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    release_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_release(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (!key_held) done = 1'b1;
    end
    check(tag, done, 1'b1);
  endtask

  logic [3:0] exp_col [4];
  int         base;
  logic [3:0] digit_before;

  initial begin
    checks       = 0;
    failures     = 0;
    latch_cnt    = 0;
    double_latch = 0;
    latch_prev   = 1'b0;
    exp_col      = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    release_all();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_col", col_out, 4'b1110);
    check("rst_digit", user_digit, 4'h0);
    check("rst_latch", user_latch, 1'b0);
    check("rst_held", key_held, 1'b0);

    // 1: idle scan, each column held 4 cycles
    do_reset();
    for (int k = 0; k < 20; k++) begin
      check($sformatf("scan_col_k%0d", k), col_out, exp_col[(k / 4) % 4]);
      check($sformatf("scan_latch_k%0d", k), user_latch, 1'b0);
      @(negedge clk);
    end

    // 2: key 5 (row1/col1); sample at posedge 8, strobe visible after posedge 16
    do_reset();
    base = latch_cnt;
    pressed[1][1] = 1'b1;
    repeat (15) @(negedge clk);
    check("k5_latch_k15", user_latch, 1'b0);
    @(negedge clk);
    check("k5_latch_k16", user_latch, 1'b1);
    check("k5_digit", user_digit, 4'h5);
    check("k5_held", key_held, 1'b1);
    @(negedge clk);
    check("k5_latch_k17", user_latch, 1'b0);
    repeat (13) @(negedge clk);
    check("k5_col_held", col_out, 4'b1101);
    check("k5_count", latch_cnt - base, 1);
    pressed[1][1] = 1'b0;
    repeat (9) @(negedge clk);
    check("k5_held_k39", key_held, 1'b1);
    @(negedge clk);
    check("k5_held_k40", key_held, 1'b0);
    check("k5_next_col", col_out, 4'b1011);

    // 3: bouncing key A on column 3
    base = latch_cnt;
    for (int i = 0; i < 20; i++) begin
      pressed[0][3] = ~pressed[0][3];
      repeat (3) @(negedge clk);
    end
    pressed[0][3] = 1'b0;
    repeat (4) @(negedge clk);
    check("bounce_count", latch_cnt - base, 0);
    check("bounce_held", key_held, 1'b0);
    check("bounce_digit", user_digit, 4'h5);
    begin
      bit seen0, seen3;
      seen0 = 1'b0;
      seen3 = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (col_out == 4'b1110) seen0 = 1'b1;
        if (col_out == 4'b0111) seen3 = 1'b1;
      end
      check("bounce_scan_c0", seen0, 1'b1);
      check("bounce_scan_c3", seen3, 1'b1);
    end

    // 4: key E (row3/col0) held 100 cycles
    base = latch_cnt;
    digit_before = user_digit;
    pressed[3][0] = 1'b1;
    repeat (100) @(negedge clk);
`ifdef KEYPAD_DECIMAL_FILTER_EN
    check("kE_count", latch_cnt - base, 0);
    check("kE_digit", user_digit, digit_before);
`else
    check("kE_count", latch_cnt - base, 1);
    check("kE_digit", user_digit, 4'hE);
`endif
    check("kE_held", key_held, 1'b1);
    pressed[3][0] = 1'b0;
    wait_release("kE_release");

    // 5: rows 0 and 2 on column 1, lowest row wins
    base = latch_cnt;
    pressed[0][1] = 1'b1;
    pressed[2][1] = 1'b1;
    repeat (60) @(negedge clk);
    check("multi_count", latch_cnt - base, 1);
    check("multi_digit", user_digit, 4'h2);
    check("multi_held", key_held, 1'b1);
    release_all();
    wait_release("multi_release");

    // 6: reset while PRESS_DB count is 5 (after posedge 13)
    do_reset();
    base = latch_cnt;
    pressed[1][1] = 1'b1;
    repeat (13) @(negedge clk);
    check("abort_pre_latch", user_latch, 1'b0);
    check("abort_pre_col", col_out, 4'b1101);
    reset = 1'b1;
    #1;
    check("abort_col", col_out, 4'b1110);
    check("abort_latch", user_latch, 1'b0);
    check("abort_held", key_held, 1'b0);
    check("abort_digit", user_digit, 4'h0);
    release_all();
    @(negedge clk);
    reset = 1'b0;
    check("resume_k0", col_out, 4'b1110);
    repeat (4) @(negedge clk);
    check("resume_k4", col_out, 4'b1101);
    repeat (20) @(negedge clk);
    check("abort_count", latch_cnt - base, 0);
    check("no_double_latch", double_latch, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
